// File: rtl/hpu_qual_credit_rx.sv
`default_nettype none
// ============================================================================
// Module   : hpu_qual_credit_rx
// Brief    : Credit-based receive buffer behind a qualified SLL crossing.
//            Beats are stored in a DEPTH-entry circular buffer, and each freed
//            entry returns one credit pulse. Define HPU_QUAL_CREDIT_RX_BYPASS_EN
//            to enable the zero-latency empty-buffer bypass.
// Revision : 1.0 - initial release
// ============================================================================
module hpu_qual_credit_rx #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8
) (
    input  logic                         clk,
    input  logic                         s_rst_n,
    input  logic [DATA_WIDTH-1:0]        in_data,
    input  logic                         in_avail,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic                         out_vld,
    input  logic                         out_rdy,
    output logic                         credit_return,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy,
    output logic                         overflow_err
);

    localparam int                 c_ptr_w    = $clog2(DEPTH);
    localparam int                 c_occ_w    = $clog2(DEPTH + 1);
    localparam logic [c_ptr_w-1:0] c_ptr_last = c_ptr_w'(DEPTH - 1);
    localparam logic [c_ptr_w-1:0] c_ptr_one  = c_ptr_w'(1);
    localparam logic [c_occ_w-1:0] c_occ_full = c_occ_w'(DEPTH);
    localparam logic [c_occ_w-1:0] c_occ_one  = c_occ_w'(1);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [c_ptr_w-1:0]    r_wr_ptr;
    logic [c_ptr_w-1:0]    r_rd_ptr;
    logic [c_occ_w-1:0]    r_occ;
    logic                  r_credit;
    logic                  r_ovf;

    logic w_push;
    logic w_buf_vld;
    logic w_full;
    logic w_pop;
    logic w_write;
    logic w_drop;
    logic w_credit_set;

    // Wrap explicitly so non-power-of-2 depths never address past the array.
    function automatic logic [c_ptr_w-1:0] f_ptr_inc(input logic [c_ptr_w-1:0] ptr);
        return (ptr == c_ptr_last) ? '0 : (ptr + c_ptr_one);
    endfunction

    // Beats arriving while reset is held are discarded outright.
    assign w_push    = in_avail & s_rst_n;
    assign w_buf_vld = (r_occ != '0);
    assign w_full    = (r_occ == c_occ_full);
    assign w_pop     = w_buf_vld & out_rdy;

`ifdef HPU_QUAL_CREDIT_RX_BYPASS_EN
    logic w_bypass;
    logic w_bypass_take;

    // An accepted bypass beat never touches storage but still frees a credit.
    assign w_bypass      = w_push & ~w_buf_vld;
    assign w_bypass_take = w_bypass & out_rdy;
    assign w_write       = w_push & ~w_bypass_take & (~w_full | w_pop);
    assign w_credit_set  = w_pop | w_bypass_take;
    assign out_vld       = w_buf_vld | w_bypass;
    assign out_data      = w_bypass ? in_data : r_mem[r_rd_ptr];
`else
    assign w_write       = w_push & (~w_full | w_pop);
    assign w_credit_set  = w_pop;
    assign out_vld       = w_buf_vld;
    assign out_data      = r_mem[r_rd_ptr];
`endif

    assign w_drop        = w_push & w_full & ~w_pop;

    assign credit_return = r_credit;
    assign occupancy     = r_occ;
    assign overflow_err  = r_ovf;

    always_ff @(posedge clk) begin
        if (!s_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
            r_credit <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_credit <= w_credit_set;
            if (w_write) begin
                r_wr_ptr <= f_ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= f_ptr_inc(r_rd_ptr);
            end
            if (w_write && !w_pop) begin
                r_occ <= r_occ + c_occ_one;
            end else if (w_pop && !w_write) begin
                r_occ <= r_occ - c_occ_one;
            end
            if (w_drop) begin
                r_ovf <= 1'b1;
            end
        end
    end

    // Storage is intentionally left out of reset.
    always_ff @(posedge clk) begin
        if (w_write) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hpu_qual_credit_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_hpu_qual_credit_rx
// Brief    : Self-checking bench for hpu_qual_credit_rx (DEPTH=8 and DEPTH=5),
//            queue-style reference model plus directed literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hpu_qual_credit_rx;

    localparam int DW   = 16;
    localparam int MASK = 4095;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n    [2];
    logic [DW-1:0] in_data  [2];
    logic          in_avail [2];
    logic          out_rdy  [2];
    logic [DW-1:0] out_data [2];
    logic          out_vld  [2];
    logic          credit   [2];
    logic          ovf      [2];
    logic [3:0]    occ0;
    logic [2:0]    occ1;

    hpu_qual_credit_rx #(.DATA_WIDTH(DW), .DEPTH(8)) u_dut8 (
        .clk           (clk),
        .s_rst_n       (rst_n[0]),
        .in_data       (in_data[0]),
        .in_avail      (in_avail[0]),
        .out_data      (out_data[0]),
        .out_vld       (out_vld[0]),
        .out_rdy       (out_rdy[0]),
        .credit_return (credit[0]),
        .occupancy     (occ0),
        .overflow_err  (ovf[0])
    );

    hpu_qual_credit_rx #(.DATA_WIDTH(DW), .DEPTH(5)) u_dut5 (
        .clk           (clk),
        .s_rst_n       (rst_n[1]),
        .in_data       (in_data[1]),
        .in_avail      (in_avail[1]),
        .out_data      (out_data[1]),
        .out_vld       (out_vld[1]),
        .out_rdy       (out_rdy[1]),
        .credit_return (credit[1]),
        .occupancy     (occ1),
        .overflow_err  (ovf[1])
    );

    // Reference model: an unbounded FIFO as monotonic head/tail sequence numbers.
    logic [DW-1:0] mdata [2][MASK+1];
    int            mhead  [2];
    int            mtail  [2];
    bit            mcredit[2];
    bit            movf   [2];
    bit            mvalid [2];
    int            n_pop  [2];
    int            n_cred [2];
    int            n_vec = 0;
    int            n_err = 0;

    task automatic chk(input int k, input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL dut%0d %s: actual %0h required %0h at %0t", k, name, act, exp, $time);
        end
    endtask

    task automatic model(input int k);
        int            dep;
        int            cnt;
        bit            bypass;
        bit            exp_vld;
        bit            pop;
        logic [DW-1:0] exp_data;
        logic [63:0]   occ_act;
        dep     = (k == 0) ? 8 : 5;
        cnt     = mtail[k] - mhead[k];
        bypass  = 1'b0;
        occ_act = (k == 0) ? {60'd0, occ0} : {61'd0, occ1};
`ifdef HPU_QUAL_CREDIT_RX_BYPASS_EN
        bypass  = (rst_n[k] === 1'b1) && (in_avail[k] === 1'b1) && (cnt == 0);
`endif
        exp_vld  = (cnt != 0) || bypass;
        exp_data = bypass ? in_data[k] : mdata[k][mhead[k] & MASK];
        if (mvalid[k]) begin
            chk(k, "out_vld", out_vld[k], exp_vld);
            if (exp_vld) chk(k, "out_data", out_data[k], exp_data);
            chk(k, "occupancy", occ_act, cnt);
            chk(k, "credit_return", credit[k], mcredit[k]);
            chk(k, "overflow_err", ovf[k], movf[k]);
            if (credit[k] === 1'b1) n_cred[k]++;
        end
        if (rst_n[k] !== 1'b1) begin
            mhead[k]   = mtail[k];
            mcredit[k] = 1'b0;
            movf[k]    = 1'b0;
            mvalid[k]  = 1'b1;
        end else if (mvalid[k]) begin
            pop        = exp_vld && (out_rdy[k] === 1'b1);
            mcredit[k] = pop;
            if (pop) n_pop[k]++;
            if (!(bypass && out_rdy[k] === 1'b1)) begin
                if (pop) mhead[k]++;
                if (in_avail[k] === 1'b1) begin
                    if (cnt < dep || pop) begin
                        mdata[k][mtail[k] & MASK] = in_data[k];
                        mtail[k]++;
                    end else begin
                        movf[k] = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic go();
        @(negedge clk);
        model(0);
        model(1);
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        go();
        nxt();
    endtask

    task automatic set0(input bit av, input logic [DW-1:0] d, input bit rdy);
        in_avail[0] = av;
        in_data[0]  = d;
        out_rdy[0]  = rdy;
    endtask

    task automatic rand_in(input int k, input int rst_odds);
        rst_n[k]    = ($urandom_range(0, rst_odds - 1) != 0);
        in_avail[k] = ($urandom_range(0, 2) != 0);
        out_rdy[k]  = ($urandom_range(0, 1) == 1);
        in_data[k]  = DW'($urandom());
    endtask

    initial begin
        int  scr;
        int  sent;
        int  pbase;
        int  cbase;
        bit  done;
        for (int k = 0; k < 2; k++) begin
            rst_n[k] = 1'b0; in_avail[k] = 1'b0; in_data[k] = '0; out_rdy[k] = 1'b0;
            mhead[k] = 0; mtail[k] = 0; mcredit[k] = 1'b0; movf[k] = 1'b0;
            mvalid[k] = 1'b0; n_pop[k] = 0; n_cred[k] = 0;
        end
        nxt();
        step();
        step();
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;

`ifndef HPU_QUAL_CREDIT_RX_BYPASS_EN
        // Three-beat pass-through with a ready consumer.
        set0(1'b1, 16'h11, 1'b1); go();
        chk(0, "rst_vld", out_vld[0], 0); chk(0, "rst_occ", occ0, 0);
        chk(0, "rst_credit", credit[0], 0); chk(0, "rst_ovf", ovf[0], 0); nxt();
        set0(1'b1, 16'h22, 1'b1); go();
        chk(0, "p1_vld", out_vld[0], 1); chk(0, "p1_data", out_data[0], 16'h11);
        chk(0, "p1_credit", credit[0], 0); nxt();
        set0(1'b1, 16'h33, 1'b1); go();
        chk(0, "p2_data", out_data[0], 16'h22); chk(0, "p2_credit", credit[0], 1); nxt();
        set0(1'b0, 16'h0, 1'b1); go();
        chk(0, "p3_data", out_data[0], 16'h33); chk(0, "p3_credit", credit[0], 1); nxt();
        go();
        chk(0, "p4_credit", credit[0], 1); chk(0, "p4_vld", out_vld[0], 0); nxt();
        go();
        chk(0, "p5_credit", credit[0], 0); nxt();
`else
        set0(1'b0, 16'h0, 1'b1); go();
        chk(0, "rst_vld", out_vld[0], 0); chk(0, "rst_occ", occ0, 0);
        chk(0, "rst_credit", credit[0], 0); chk(0, "rst_ovf", ovf[0], 0); nxt();
        set0(1'b1, 16'h5A, 1'b1); go();
        chk(0, "byp_vld", out_vld[0], 1); chk(0, "byp_data", out_data[0], 16'h5A);
        chk(0, "byp_occ", occ0, 0); nxt();
        set0(1'b0, 16'h0, 1'b1); go();
        chk(0, "byp_credit", credit[0], 1); chk(0, "byp_occ2", occ0, 0);
        chk(0, "byp_vld2", out_vld[0], 0); nxt();
`endif

        // Fill to full, then overflow with a ninth beat.
        for (int i = 0; i < 8; i++) begin
            set0(1'b1, DW'(16'hA0 + i), 1'b0); step();
        end
        set0(1'b1, 16'hFF, 1'b0); go();
        chk(0, "full_occ", occ0, 8); chk(0, "full_ovf", ovf[0], 0); nxt();
        set0(1'b0, 16'h0, 1'b0); go();
        chk(0, "ovf_set", ovf[0], 1); chk(0, "ovf_occ", occ0, 8); nxt();
        set0(1'b0, 16'h0, 1'b1); go();
        chk(0, "drain_head", out_data[0], 16'hA0); nxt();
        for (int i = 0; i < 8; i++) step();

        rst_n[0] = 1'b0; set0(1'b0, 16'h0, 1'b0); step();
        rst_n[0] = 1'b1;

        // Sustained push+pop at full across pointer wrap.
        for (int i = 0; i < 8; i++) begin
            set0(1'b1, DW'(16'h30 + i), 1'b0); step();
        end
        cbase = n_cred[0];
        for (int i = 0; i < 20; i++) begin
            set0(1'b1, DW'(16'h60 + i), 1'b1); step();
        end
        set0(1'b0, 16'h0, 1'b0); go();
        chk(0, "sat_occ", occ0, 8); chk(0, "sat_ovf", ovf[0], 0);
        chk(0, "sat_credits", n_cred[0] - cbase, 20); nxt();

        // Reset at occupancy 4 right after a pop.
        for (int i = 0; i < 4; i++) begin
            set0(1'b0, 16'h0, 1'b1); step();
        end
        rst_n[0] = 1'b0; set0(1'b1, 16'h77, 1'b1); go();
        chk(0, "pre_rst_occ", occ0, 4); chk(0, "pre_rst_credit", credit[0], 1); nxt();
        rst_n[0] = 1'b1; set0(1'b0, 16'h0, 1'b0); go();
        chk(0, "post_rst_credit", credit[0], 0); chk(0, "post_rst_vld", out_vld[0], 0);
        chk(0, "post_rst_occ", occ0, 0); nxt();
        set0(1'b1, 16'hAA, 1'b0); step();
        set0(1'b0, 16'h0, 1'b1); go();
        chk(0, "post_rst_head", out_data[0], 16'hAA); nxt();
        step();

        // DEPTH=5 credit-looped stream of 13 beats while DEPTH=8 runs randomly.
        scr = 5; sent = 0; done = 1'b0;
        pbase = n_pop[1]; cbase = n_cred[1];
        for (int c = 0; c < 400 && !done; c++) begin
            rand_in(0, 100);
            in_avail[1] = (scr > 0) && (sent < 13);
            in_data[1]  = DW'(16'hC0 + sent);
            out_rdy[1]  = ($urandom_range(0, 1) == 1);
            if (in_avail[1]) begin
                scr--;
                sent++;
            end
            go();
            if (credit[1] === 1'b1) scr++;
            done = (sent == 13) && (mtail[1] == mhead[1]) && !mcredit[1];
            nxt();
        end
        chk(1, "stream_done", done, 1);
        chk(1, "stream_pops", n_pop[1] - pbase, 13);
        chk(1, "stream_credits", n_cred[1] - cbase, 13);
        chk(1, "sender_credits", scr, 5);

        // Free-running random traffic on both depths, including overflow and resets.
        for (int c = 0; c < 600; c++) begin
            rand_in(0, 120);
            rand_in(1, 150);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hpu_qual_credit_rx.md
HPU_QUAL_CREDIT_RX -- requirements
Module: hpu_qual_credit_rx

Interface
REQ-001 The block SHALL expose the following parameter: DATA_WIDTH, default 32, payload width in bits.
REQ-002 The block SHALL expose the following parameter: DEPTH, default 8, buffer entries and credit count, legal range 2..64.
REQ-003 The block SHALL provide port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 The block SHALL provide port s_rst_n, input, 1, synchronous active-low reset.
REQ-005 The block SHALL provide port in_data, input, DATA_WIDTH, payload from the qualified SLL crossing.
REQ-006 The block SHALL provide port in_avail, input, 1, payload qualifier; there is no backpressure toward the crossing.
REQ-007 The block SHALL provide port out_data, output, DATA_WIDTH, head-of-buffer payload.
REQ-008 The block SHALL provide port out_vld, output, 1, out_data is valid.
REQ-009 The block SHALL provide port out_rdy, input, 1, consumer accepts.
REQ-010 The block SHALL provide port credit_return, output, 1, one-cycle pulse per freed entry, sent back through the return crossing.
REQ-011 The block SHALL provide port occupancy, output, $clog2(DEPTH+1), entries currently held.
REQ-012 The block SHALL provide port overflow_err, output, 1, sticky overflow flag.

Function
REQ-013 The block SHALL store each in_avail=1 beat in a DEPTH-entry circular buffer, in arrival order.
REQ-014 Push in cycle N SHALL make the beat visible at out_data/out_vld in cycle N+1 when the buffer was empty.
REQ-015 out_vld SHALL equal (occupancy != 0), and out_data SHALL be the oldest entry, stable while out_vld=1 and out_rdy=0.
REQ-016 A pop SHALL occur when out_vld=1 and out_rdy=1; read pointer +1 modulo DEPTH.
REQ-017 Each pop in cycle N SHALL produce credit_return=1 in cycle N+1 only; back-to-back pops give back-to-back pulses.
REQ-018 Push and pop in the same cycle SHALL leave occupancy unchanged and be legal at any occupancy, including full.
REQ-019 Push at occupancy=DEPTH with no pop SHALL drop the beat, leave buffer and pointers unchanged, and set overflow_err to 1 from the next cycle.
REQ-020 Pointers SHALL wrap from DEPTH-1 to 0, also for non-power-of-2 DEPTH.
REQ-021 occupancy SHALL be a register updated as +1 on push only, -1 on pop only, and unchanged otherwise.
REQ-022 The block SHALL issue no credits at reset; the sender initialises its credit counter to DEPTH.
REQ-023 Pop from an empty buffer SHALL be impossible; out_rdy SHALL be ignored when out_vld=0.

Reset
REQ-024 While s_rst_n=0, the following SHALL hold on the next edge: out_vld=0, credit_return=0, occupancy=0, overflow_err=0, pointers=0.
REQ-025 out_data SHALL be don't-care during reset, and buffer storage SHALL NOT be reset.
REQ-026 Reset mid-operation SHALL discard all held entries without credit pulses, and a pending credit pulse SHALL be cancelled.
REQ-027 in_avail SHALL be ignored while s_rst_n=0.

Configuration
REQ-028 Macro HPU_QUAL_CREDIT_RX_BYPASS_EN SHALL control a zero-latency bypass.
REQ-029 When HPU_QUAL_CREDIT_RX_BYPASS_EN is defined and occupancy=0, in_avail=1 SHALL drive out_vld=1 and out_data=in_data in the same cycle.
REQ-030 With the bypass active and out_rdy=1, the beat SHALL NOT be written, occupancy SHALL stay 0, and credit_return SHALL pulse in the next cycle.
REQ-031 With the bypass active and out_rdy=0, the beat SHALL be written normally.
REQ-032 When HPU_QUAL_CREDIT_RX_BYPASS_EN is undefined, no combinational path SHALL exist from in_* to out_*, and REQ-014 SHALL apply.

Verification
REQ-033 Scenario: DEPTH=8, with out_rdy=1, push 0x11,0x22,0x33 in cycles 0,1,2 -> out_data 0x11,0x22,0x33 in cycles 1,2,3, and credit_return high in cycles 2,3,4.
REQ-034 Scenario: with out_rdy=0, push 8 beats -> occupancy=8 and overflow_err=0; then push a 9th beat -> overflow_err=1 and occupancy=8, and draining yields the first 8 values in order.
REQ-035 Scenario: at full (8), push and pop each cycle for 20 cycles -> occupancy stays 8, no overflow, 20 credit pulses, and order preserved across wrap.
REQ-036 Scenario: DEPTH=5, stream 13 beats with random out_rdy -> all 13 received in order, and the total of 13 credit pulses equals the number of pops.
REQ-037 Scenario: reset asserted with occupancy=4 and a pop in the prior cycle -> next cycle credit_return=0, out_vld=0, occupancy=0; after release, a new push 0xAA appears first.
REQ-038 Scenario: with HPU_QUAL_CREDIT_RX_BYPASS_EN defined, empty buffer, push 0x5A with out_rdy=1 -> out_vld=1 and out_data=0x5A in the same cycle, occupancy stays 0, and credit_return=1 in the next cycle.
